// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command parser between a UART receiver and transmitter.
// Decodes a byte stream into writes/reads of four 8-bit registers, reads of
// gp_in and a sticky status byte, and sends one response byte per command
// over the shared transmitter using its busy handshake.
//
// Optional feature: define UART_CMD_TIMEOUT_EN to build an inter-byte
// timeout in GET_DATA (TIMEOUT_CYCLES clk cycles). Without it GET_DATA
// waits forever and timeout_flag reads 0.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rx_ready, rx_data   received byte strobe / data
//   tx_busy             transmitter busy
//   tx_start, tx_data   response launch pulse / response byte
//   gp_in               general-purpose inputs (read by opcode 0x04)
//   reg0_out..reg3_out  writable registers
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic [7:0] gp_in,
  output logic [7:0] reg0_out,
  output logic [7:0] reg1_out,
  output logic [7:0] reg2_out,
  output logic [7:0] reg3_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GET  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      aa_q, aa_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            ovr_q, ovr_d;
  logic            wcnt_q, wcnt_d;
  logic            ovr_set, stat_clr, tmo_set;
  logic            tmo_flag;
  logic            expire;
  logic [7:0]      status;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  // Counter only advances in GET_DATA; any other state holds it at zero so
  // it is clear on every entry. Expiry falls on the TIMEOUT_CYCLES-th cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_GET) cnt_d = cnt_q + 1'b1;
  end
  assign expire   = (state_q == S_GET) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign tmo_d    = (stat_clr ? 1'b0 : tmo_q) | tmo_set;
  assign tmo_flag = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0) | tmo_set;
  assign expire         = 1'b0;
  assign tmo_flag       = 1'b0;
`endif

  assign status = {6'b0, tmo_flag, ovr_q};

  always_comb begin
    state_d    = state_q;
    aa_d       = aa_q;
    regs_d     = regs_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    wcnt_d     = wcnt_q;
    ovr_set    = 1'b0;
    stat_clr   = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          state_d = S_SEND;
          if (rx_data[7:2] == 6'b100000) begin
            aa_d    = rx_data[1:0];
            state_d = S_GET;
          end else if (rx_data[7:2] == 6'b000000) begin
            tx_data_d = regs_q[rx_data[1:0]];
          end else if (rx_data == 8'h04) begin
            tx_data_d = gp_in;
          end else if (rx_data == 8'h05) begin
            // Response carries the value before the clear.
            tx_data_d = status;
            stat_clr  = 1'b1;
          end else begin
            tx_data_d = 8'hEE;
          end
        end
      end
      S_GET: begin
        // A data byte on the expiry cycle still wins over the timeout.
        if (rx_ready) begin
          regs_d[aa_q] = rx_data;
          tx_data_d    = {6'b101000, aa_q};
          state_d      = S_SEND;
        end else if (expire) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (rx_ready) ovr_set = 1'b1;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          wcnt_d     = 1'b0;
          state_d    = S_WAIT;
        end
      end
      default: begin
        // Transmitter busy is registered, so give it up to two cycles to
        // rise before another response could be launched.
        if (rx_ready) ovr_set = 1'b1;
        if (tx_busy || wcnt_q) state_d = S_IDLE;
        else                   wcnt_d  = 1'b1;
      end
    endcase
  end

  // Set beats clear when both land in the same cycle.
  assign ovr_d = (stat_clr ? 1'b0 : ovr_q) | ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      aa_q       <= 2'd0;
      regs_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ovr_q      <= 1'b0;
      wcnt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aa_q       <= aa_d;
      regs_q     <= regs_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovr_q      <= ovr_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign reg0_out = regs_q[0];
  assign reg1_out = regs_q[1];
  assign reg2_out = regs_q[2];
  assign reg3_out = regs_q[3];

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1_000_000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] gp_in = 8'h00;
  logic [7:0] reg0_out, reg1_out, reg2_out, reg3_out;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .gp_in(gp_in),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
    .reg3_out(reg3_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_cyc = 0;
  int last_start = 0;
  int n_start = 0;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mreg[4];
  logic [7:0] mstat = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every launched response pops one expected byte.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      chk("no_busy_start", tx_busy, 0);
      chk("no_double_start", prev_start, 0);
      chk("pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("resp", tx_data, exp_q.pop_front());
      last_start = cyc;
      n_start++;
    end
    prev_start = tx_start;
  end

  function automatic logic [7:0] rout(input logic [1:0] a);
    case (a)
      2'd0: return reg0_out;
      2'd1: return reg1_out;
      2'd2: return reg2_out;
      default: return reg3_out;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    rx_cyc   = cyc;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back(8'hA0 | {6'b0, a});
    send(8'h80 | {6'b0, a});
    send(d);
    mreg[a] = d;
    chk("wr_reg", rout(a), d);
    drain();
    chk("wr_lat", last_start - rx_cyc, 2);
  endtask

  task automatic do_read(input logic [7:0] op);
    logic [7:0] e;
    if (op < 8'h04) e = mreg[op[1:0]];
    else if (op == 8'h04) e = gp_in;
    else if (op == 8'h05) begin e = mstat; mstat = 8'h00; end
    else e = 8'hEE;
    exp_q.push_back(e);
    send(op);
    chk("rd_txdata_early", tx_data, e);
    drain();
    chk("rd_lat", last_start - rx_cyc, 2);
  endtask

  initial begin
    int n0, kc;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_regs", {reg0_out, reg1_out, reg2_out, reg3_out}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back, several addresses and patterns.
    do_write(2'd1, 8'h5A);
    do_read(8'h01);
    do_write(2'd3, 8'h77);
    do_write(2'd0, 8'hFF);
    do_write(2'd2, 8'h3C);
    do_read(8'h03);
    do_read(8'h00);
    do_read(8'h02);

    // GP and error opcodes.
    gp_in = 8'hC3;
    do_read(8'h04);
    do_read(8'h37);
    do_read(8'hFF);
    do_read(8'h84 & 8'h7F);
    chk("err_no_change", {reg0_out, reg1_out, reg2_out, reg3_out},
        {mreg[0], mreg[1], mreg[2], mreg[3]});

    // Busy handshake: launch only after busy falls, exactly once.
    tx_busy = 1'b1;
    exp_q.push_back(mreg[1]);
    n0 = n_start;
    send(8'h01);
    repeat (500) @(negedge clk);
    chk("busy_hold", n_start - n0, 0);
    tx_busy = 1'b0;
    kc = cyc;
    drain();
    chk("busy_lat", last_start - kc, 1);
    repeat (10) @(negedge clk);
    chk("busy_once", n_start - n0, 1);

    // Overrun: a byte arriving while the response is pending is dropped.
    exp_q.push_back(mreg[2]);
    send(8'h02);
    send(8'h01);
    mstat = mstat | 8'h01;
    drain();
    chk("ovr_one_resp", exp_q.size(), 0);
    do_read(8'h05);
    do_read(8'h05);

`ifdef UART_CMD_TIMEOUT_EN
    // Timeout: partial write dropped, flag set, nothing sent.
    n0 = n_start;
    send(8'h82);
    repeat (110) @(negedge clk);
    chk("tmo_no_resp", n_start - n0, 0);
    chk("tmo_reg2", reg2_out, mreg[2]);
    mstat = mstat | 8'h02;
    do_read(8'h05);
    // Data byte landing on the expiry cycle is still accepted.
    exp_q.push_back(8'hA2);
    send(8'h82);
    kc = rx_cyc;
    repeat (TO - 2) @(negedge clk);
    send(8'h96);
    chk("tmo_edge_cycle", rx_cyc - kc, TO);
    mreg[2] = 8'h96;
    chk("tmo_edge_reg", reg2_out, 8'h96);
    drain();
    do_read(8'h05);
`endif

    // Reset mid GET_DATA drops the partial command and clears everything.
    send(8'h80);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_regs", {reg0_out, reg1_out, reg2_out, reg3_out}, 32'h0);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_tx_start", tx_start, 0);
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mstat = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    do_read(8'h02);
    do_read(8'h03);
    do_read(8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
